// File: rtl/mips_multi_cycle_ctrl.sv
// Multicycle MIPS control FSM with per-state memory-wait timeout and sticky trap/bus-error states.
// Optional retired-instruction counter is built only when macro MIPS_MC_INST_CNT_EN is defined.
module mips_multi_cycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             branch_ne,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic [2:0]       alu_ctrl,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] inst_count
);

  localparam int unsigned WAIT_W = 8;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, R_EX, R_WB,
    I_EX, I_WB, BRANCH, JUMP, JAL, JR, TRAP, BUSERR
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_ctrl;
    logic       illegal;
    logic       bus_err;
  } ctrl_t;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic              func_ok, timeout, wait_state;
  logic [2:0]        r_alu;
  logic              unused_zero;

  // The branch outcome is resolved in the datapath through pc_write_cond.
  assign unused_zero = zero;

  function automatic ctrl_t fetch_ctrl();
    ctrl_t c;
    c           = '0;
    c.mem_read  = 1'b1;
    c.alu_src_b = 2'b01;
    c.alu_ctrl  = 3'b010;
    return c;
  endfunction

  always_comb begin
    r_alu   = 3'b000;
    func_ok = 1'b1;
    case (func)
      6'b100000: r_alu = 3'b010;
      6'b100010: r_alu = 3'b110;
      6'b100100: r_alu = 3'b000;
      6'b100101: r_alu = 3'b001;
      6'b101010: r_alu = 3'b111;
      default:   func_ok = 1'b0;
    endcase
  end

  assign wait_state = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
  assign timeout    = !mem_ready && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (mem_ready) state_d = DECODE; else if (timeout) state_d = BUSERR;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW:     state_d = MEM_ADR;
          OP_RTYPE:         state_d = (func == FN_JR) ? JR : R_EX;
          OP_ADDI, OP_SLTI: state_d = I_EX;
          OP_BEQ, OP_BNE:   state_d = BRANCH;
          OP_J:             state_d = JUMP;
          OP_JAL:           state_d = JAL;
          default:          state_d = TRAP;
        endcase
      end
      MEM_ADR: state_d = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:  if (mem_ready) state_d = MEM_WB; else if (timeout) state_d = BUSERR;
      MEM_WR:  if (mem_ready) state_d = FETCH; else if (timeout) state_d = BUSERR;
      R_EX:    state_d = func_ok ? R_WB : TRAP;
      I_EX:    state_d = I_WB;
      TRAP:    state_d = TRAP;
      BUSERR:  state_d = BUSERR;
      default: state_d = FETCH;
    endcase
  end

  // Wait counter runs only while a memory state holds itself; any state change clears it.
  assign wait_d = (wait_state && (state_d == state_q)) ? wait_q + WAIT_W'(1) : '0;

  // Output word for the state being entered, so strobes are registered.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      FETCH:   ctrl_d = fetch_ctrl();
      DECODE:  begin ctrl_d.alu_src_b = 2'b11; ctrl_d.alu_ctrl = 3'b010; end
      MEM_ADR: begin ctrl_d.alu_src_a = 1'b1; ctrl_d.alu_src_b = 2'b10; ctrl_d.alu_ctrl = 3'b010; end
      MEM_RD:  begin ctrl_d.mem_read = 1'b1; ctrl_d.iord = 1'b1; end
      MEM_WB:  begin ctrl_d.reg_write = 1'b1; ctrl_d.mem_to_reg = 2'b01; end
      MEM_WR:  begin ctrl_d.mem_write = 1'b1; ctrl_d.iord = 1'b1; end
      R_EX:    begin ctrl_d.alu_src_a = 1'b1; ctrl_d.alu_ctrl = r_alu; end
      R_WB:    begin ctrl_d.reg_write = 1'b1; ctrl_d.reg_dst = 2'b01; end
      I_EX: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = 2'b10;
        ctrl_d.alu_ctrl  = (opcode == OP_SLTI) ? 3'b111 : 3'b010;
      end
      I_WB:    ctrl_d.reg_write = 1'b1;
      BRANCH: begin
        ctrl_d.alu_src_a     = 1'b1;
        ctrl_d.alu_ctrl      = 3'b110;
        ctrl_d.pc_write_cond = 1'b1;
        ctrl_d.pc_src        = 2'b01;
        ctrl_d.branch_ne     = (opcode == OP_BNE);
      end
      JUMP:    begin ctrl_d.pc_write = 1'b1; ctrl_d.pc_src = 2'b10; end
      JR:      begin ctrl_d.pc_write = 1'b1; ctrl_d.pc_src = 2'b11; end
      JAL: begin
        ctrl_d.pc_write   = 1'b1;
        ctrl_d.pc_src     = 2'b10;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.reg_dst    = 2'b10;
        ctrl_d.mem_to_reg = 2'b10;
      end
      TRAP:    ctrl_d.illegal = 1'b1;
      BUSERR:  ctrl_d.bus_err = 1'b1;
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      wait_q  <= '0;
      ctrl_q  <= fetch_ctrl();
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Instruction-register load and PC increment complete in the same cycle as the fetch.
  assign ir_write      = (state_q == FETCH) && mem_ready;
  assign pc_write      = ctrl_q.pc_write | ir_write;
  assign pc_write_cond = ctrl_q.pc_write_cond;
  assign branch_ne     = ctrl_q.branch_ne;
  assign iord          = ctrl_q.iord;
  assign mem_read      = ctrl_q.mem_read;
  assign mem_write     = ctrl_q.mem_write;
  assign reg_write     = ctrl_q.reg_write;
  assign alu_src_a     = ctrl_q.alu_src_a;
  assign reg_dst       = ctrl_q.reg_dst;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign pc_src        = ctrl_q.pc_src;
  assign alu_ctrl      = ctrl_q.alu_ctrl;
  assign illegal       = ctrl_q.illegal;
  assign bus_err       = ctrl_q.bus_err;

`ifdef MIPS_MC_INST_CNT_EN
  logic             retire;
  logic [CNT_W-1:0] cnt_q;

  assign retire = (state_q == R_WB) || (state_q == MEM_WB) || (state_q == I_WB) ||
                  (state_q == BRANCH) || (state_q == JUMP) || (state_q == JR) ||
                  (state_q == JAL) || ((state_q == MEM_WR) && mem_ready);

  always_ff @(posedge clk) begin
    if (rst)         cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign inst_count = cnt_q;
`else
  assign inst_count = '0;
`endif

endmodule

// File: tb/tb_mips_multi_cycle_ctrl.sv
// Scoreboard bench for mips_multi_cycle_ctrl: an instruction-level model queues the expected
// control word for every cycle, and a negedge monitor pops and compares against the DUT.
module tb_mips_multi_cycle_ctrl;

  localparam int unsigned TMO = 4;
  localparam int unsigned CW  = 2;

  typedef struct packed {
    logic          pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
    logic          ir_write, reg_write, alu_src_a;
    logic [1:0]    reg_dst, mem_to_reg, alu_src_b, pc_src;
    logic [2:0]    alu_ctrl;
    logic          illegal, bus_err;
    logic [CW-1:0] inst_count;
  } vec_t;

  logic clk = 1'b0;
  logic rst, zero, mem_ready;
  logic [5:0] opcode, func;
  logic pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
  logic [2:0] alu_ctrl;
  logic illegal, bus_err;
  logic [CW-1:0] inst_count;

  mips_multi_cycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .alu_ctrl(alu_ctrl), .illegal(illegal), .bus_err(bus_err),
    .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  vec_t act;
  assign act = {pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write,
                reg_write, alu_src_a, reg_dst, mem_to_reg, alu_src_b, pc_src, alu_ctrl,
                illegal, bus_err, inst_count};

  vec_t          exp_q[$];
  string         name_q[$];
  int            checks = 0;
  int            passes = 0;
  logic [CW-1:0] count_m;
  vec_t          e_v;
  string         e_name;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_v    = exp_q.pop_front();
      e_name = name_q.pop_front();
      checks++;
      if (act !== e_v)
        $display("FAIL %s cycle@%0t: got %h expected %h", e_name, $time, act, e_v);
      else
        passes++;
    end
  end

  task automatic check(input string what, input logic cond);
    checks++;
    if (cond !== 1'b1)
      $display("FAIL %s @%0t: got %h", what, $time, act);
    else
      passes++;
  endtask

  function automatic vec_t expect_step(input string s, input logic rdy, input logic [5:0] op,
                                       input logic [5:0] fn, input logic [CW-1:0] cnt);
    vec_t v;
    v = '0;
    v.inst_count = cnt;
    if (s == "FETCH") begin
      v.mem_read = 1'b1; v.alu_src_b = 2'b01; v.alu_ctrl = 3'b010;
      v.ir_write = rdy;  v.pc_write  = rdy;
    end else if (s == "DECODE") begin
      v.alu_src_b = 2'b11; v.alu_ctrl = 3'b010;
    end else if (s == "MEM_ADR") begin
      v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; v.alu_ctrl = 3'b010;
    end else if (s == "MEM_RD") begin
      v.mem_read = 1'b1; v.iord = 1'b1;
    end else if (s == "MEM_WB") begin
      v.reg_write = 1'b1; v.mem_to_reg = 2'b01;
    end else if (s == "MEM_WR") begin
      v.mem_write = 1'b1; v.iord = 1'b1;
    end else if (s == "R_EX") begin
      v.alu_src_a = 1'b1;
      case (fn)
        6'b100000: v.alu_ctrl = 3'b010;
        6'b100010: v.alu_ctrl = 3'b110;
        6'b100101: v.alu_ctrl = 3'b001;
        6'b101010: v.alu_ctrl = 3'b111;
        default:   v.alu_ctrl = 3'b000;
      endcase
    end else if (s == "R_WB") begin
      v.reg_write = 1'b1; v.reg_dst = 2'b01;
    end else if (s == "I_EX") begin
      v.alu_src_a = 1'b1; v.alu_src_b = 2'b10;
      v.alu_ctrl = (op == 6'b001010) ? 3'b111 : 3'b010;
    end else if (s == "I_WB") begin
      v.reg_write = 1'b1;
    end else if (s == "BRANCH") begin
      v.alu_src_a = 1'b1; v.alu_ctrl = 3'b110; v.pc_write_cond = 1'b1; v.pc_src = 2'b01;
      v.branch_ne = (op == 6'b000101);
    end else if (s == "JUMP") begin
      v.pc_write = 1'b1; v.pc_src = 2'b10;
    end else if (s == "JR") begin
      v.pc_write = 1'b1; v.pc_src = 2'b11;
    end else if (s == "JAL") begin
      v.pc_write = 1'b1; v.pc_src = 2'b10; v.reg_write = 1'b1;
      v.reg_dst = 2'b10; v.mem_to_reg = 2'b10;
    end else if (s == "TRAP") begin
      v.illegal = 1'b1;
    end else if (s == "BUSERR") begin
      v.bus_err = 1'b1;
    end
    return v;
  endfunction

  task automatic step(input string s, input logic rdy);
    mem_ready = rdy;
    zero      = 1'($urandom);
    exp_q.push_back(expect_step(s, rdy, opcode, func, count_m));
    name_q.push_back(s);
    @(posedge clk);
    #1;
  endtask

  task automatic retire();
`ifdef MIPS_MC_INST_CNT_EN
    count_m = CW'(count_m + 1'b1);
`endif
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    mem_ready = 1'($urandom);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    count_m = '0;
  endtask

  // Memory wait of dly low cycles then a ready cycle; TMO or more low cycles is a bus error.
  task automatic mem_wait(input string s, input int dly, output bit ok);
    for (int i = 0; i < dly && i < int'(TMO); i++) step(s, 1'b0);
    if (dly >= int'(TMO)) begin
      ok = 1'b0;
    end else begin
      step(s, 1'b1);
      ok = 1'b1;
    end
  endtask

  task automatic halt(input string s);
    repeat (3) step(s, 1'($urandom));
    do_reset();
  endtask

  function automatic bit legal_r(input logic [5:0] fn);
    return fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
           fn == 6'b100101 || fn == 6'b101010;
  endfunction

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fdly, input int mdly);
    bit ok;
    opcode = op;
    func   = fn;
    mem_wait("FETCH", fdly, ok);
    if (!ok) begin halt("BUSERR"); return; end
    step("DECODE", 1'($urandom));
    if (op == 6'b100011 || op == 6'b101011) begin
      step("MEM_ADR", 1'($urandom));
      mem_wait((op == 6'b100011) ? "MEM_RD" : "MEM_WR", mdly, ok);
      if (!ok) begin halt("BUSERR"); return; end
      if (op == 6'b100011) step("MEM_WB", 1'($urandom));
      retire();
    end else if (op == 6'b000000) begin
      if (fn == 6'b001000) begin
        step("JR", 1'($urandom)); retire();
      end else begin
        step("R_EX", 1'($urandom));
        if (!legal_r(fn)) begin halt("TRAP"); return; end
        step("R_WB", 1'($urandom)); retire();
      end
    end else if (op == 6'b001000 || op == 6'b001010) begin
      step("I_EX", 1'($urandom)); step("I_WB", 1'($urandom)); retire();
    end else if (op == 6'b000100 || op == 6'b000101) begin
      step("BRANCH", 1'($urandom)); retire();
    end else if (op == 6'b000010) begin
      step("JUMP", 1'($urandom)); retire();
    end else if (op == 6'b000011) begin
      step("JAL", 1'($urandom)); retire();
    end else begin
      halt("TRAP");
    end
  endtask

  function automatic logic [5:0] rand_op();
    case ($urandom_range(0, 10))
      0: return 6'b100011;
      1: return 6'b101011;
      2, 3: return 6'b000000;
      4: return 6'b001000;
      5: return 6'b001010;
      6: return 6'b000100;
      7: return 6'b000101;
      8: return 6'b000010;
      9: return 6'b000011;
      default: return 6'($urandom);
    endcase
  endfunction

  function automatic logic [5:0] rand_fn();
    case ($urandom_range(0, 7))
      0: return 6'b100000;
      1: return 6'b100010;
      2: return 6'b100100;
      3: return 6'b100101;
      4: return 6'b101010;
      5: return 6'b001000;
      default: return 6'($urandom);
    endcase
  endfunction

  function automatic int rand_dly();
    if ($urandom_range(0, 19) == 0) return int'(TMO) + int'($urandom_range(0, 1));
    return int'($urandom_range(0, 3));
  endfunction

  initial begin
    rst = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = '0; func = '0; count_m = '0;
    do_reset();
    check("reset state", mem_read === 1'b1 && alu_src_b === 2'b01 && alu_ctrl === 3'b010 &&
                         iord === 1'b0 && mem_write === 1'b0 && reg_write === 1'b0 &&
                         illegal === 1'b0 && bus_err === 1'b0 && inst_count === '0);

    run_instr(6'b100011, 6'h00, 0, 0);            // lw, no waits
    run_instr(6'b000100, 6'h00, 0, 0);            // beq
    run_instr(6'b000101, 6'h00, 0, 0);            // bne
    run_instr(6'b000011, 6'h00, 0, 0);            // jal; fourth retirement wraps a 2-bit count
    run_instr(6'b000000, 6'b100010, 3, 0);        // fetch waits 3 cycles
    run_instr(6'b101011, 6'h00, 1, 2);            // sw with waits
    run_instr(6'b001010, 6'h00, 0, 0);            // slti
    run_instr(6'b000000, 6'b001000, int'(TMO) - 1, 0);
    run_instr(6'b100011, 6'h00, 0, int'(TMO));    // MEM_RD timeout
    run_instr(6'b111111, 6'h00, 0, 0);            // illegal opcode
    run_instr(6'b000000, 6'b000000, 0, 0);        // illegal func

    opcode = 6'b100011;
    func   = 6'h00;
    step("FETCH", 1'b1);
    step("DECODE", 1'b0);
    step("MEM_ADR", 1'b0);
    for (int i = 0; i < int'(TMO); i++) step("MEM_RD", 1'b0);
    check("expired wait bus_err", bus_err === 1'b1 && illegal === 1'b0 && mem_read === 1'b0 &&
                                  reg_write === 1'b0 && pc_write === 1'b0);
    halt("BUSERR");

    opcode = 6'b000010;
    step("FETCH", 1'b0);
    step("FETCH", 1'b0);
    do_reset();
    run_instr(6'b000010, 6'h00, int'(TMO) - 1, 0); // wait count restarts after reset

    for (int n = 0; n < 200; n++) run_instr(rand_op(), rand_fn(), rand_dly(), rand_dly());

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mips_multi_cycle_ctrl.md
MIPS_MULTI_CYCLE_CTRL -- requirements
Module: mips_multi_cycle_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: max cycles a memory state waits for mem_ready before bus error; legal range 1..255.
REQ-002 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 opcode  in  6  instruction bits [31:26] from the instruction register; func  in  6  bits [5:0].
REQ-006 zero  in  1  ALU zero flag; mem_ready  in  1  memory completes the current access this cycle.
REQ-007 pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a  out  1 each  standard multicycle datapath strobes.
REQ-008 reg_dst, mem_to_reg, alu_src_b, pc_src  out  2 each  datapath mux selects.
REQ-009 alu_ctrl  out  3  ALU operation code: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-010 illegal  out  1  unsupported opcode/func detected; bus_err  out  1  memory timeout.
REQ-011 inst_count  out  CNT_W  number of retired instructions.

Function
REQ-012 The FSM SHALL have the states FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, R_EX, R_WB, I_EX, I_WB, BRANCH, JUMP, JAL, JR, TRAP and BUSERR.
REQ-013 Every output not named for a state SHALL be 0 in that state.
REQ-014 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=010; ir_write and pc_write=1 only in the cycle mem_ready=1; the FSM advances to DECODE on that cycle and holds otherwise.
REQ-015 DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=010; next state by opcode: 100011/101011 MEM_ADR, 000000 R_EX (func 001000 JR), 001000/001010 I_EX, 000100/000101 BRANCH, 000010 JUMP, 000011 JAL, any other TRAP.
REQ-016 R_EX: alu_src_a=1, alu_src_b=00; alu_ctrl from func: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, any other func goes to TRAP instead of R_WB.
REQ-017 R_WB: reg_write=1, reg_dst=01, mem_to_reg=00.
REQ-018 MEM_ADR: alu_src_a=1, alu_src_b=10, alu_ctrl=010; next state MEM_RD for lw, MEM_WR for sw.
REQ-019 MEM_RD: mem_read=1, iord=1; advances to MEM_WB on mem_ready.
REQ-020 MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01.
REQ-021 MEM_WR: mem_write=1, iord=1; advances to FETCH on mem_ready.
REQ-022 I_EX: alu_src_a=1, alu_src_b=10, alu_ctrl=010 (addi) or 111 (slti).
REQ-023 I_WB: reg_write=1, reg_dst=00, mem_to_reg=00.
REQ-024 BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl=110, pc_write_cond=1, pc_src=01; branch_ne=1 for opcode 000101.
REQ-025 JUMP: pc_write=1, pc_src=10.
REQ-026 JR: pc_write=1, pc_src=11.
REQ-027 JAL: pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10.
REQ-028 R_WB, MEM_WB, I_WB, BRANCH, JUMP, JR and JAL SHALL each last one cycle and return to FETCH.
REQ-029 Each wait in FETCH, MEM_RD or MEM_WR SHALL have a cycle counter; if mem_ready stays low for MEM_TIMEOUT consecutive cycles, the FSM goes to BUSERR. The counter clears on state entry.
REQ-030 TRAP SHALL hold illegal=1 and BUSERR SHALL hold bus_err=1; each is sticky until rst, and all strobes are 0 in both states.
REQ-031 An instruction retires on the last cycle of R_WB, MEM_WB, MEM_WR (with mem_ready), I_WB, BRANCH, JUMP, JR or JAL.

Reset
REQ-032 When rst=1 at a clock edge, the FSM SHALL enter FETCH, clear the wait counter, clear illegal and bus_err, and zero inst_count, regardless of current state, including mid-wait.
REQ-033 During the first cycle after reset, outputs SHALL be the FETCH values of REQ-014.

Configuration
REQ-034 When macro MIPS_MC_INST_CNT_EN is defined, inst_count SHALL increment by 1 per retirement and wrap modulo 2^CNT_W.
REQ-035 When MIPS_MC_INST_CNT_EN is undefined, inst_count SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-036 Reset, then lw (opcode 100011) with mem_ready=1 throughout -> states FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB; reg_write=1 with mem_to_reg=01 in cycle 5; inst_count=1 (macro on).
REQ-037 beq with zero=1 -> BRANCH cycle shows pc_write_cond=1, pc_src=01, alu_ctrl=110, branch_ne=0; bne -> branch_ne=1.
REQ-038 FETCH with mem_ready low for 3 cycles, then high -> ir_write pulses once on cycle 4 only; bus_err=0.
REQ-039 MEM_TIMEOUT=4, MEM_RD with mem_ready held low -> BUSERR after 4 wait cycles, bus_err=1 until rst; then rst=1 -> FETCH, bus_err=0.
REQ-040 opcode 111111, or R-type with func 000000 -> TRAP, illegal=1, no reg_write or pc_write asserted afterwards.
REQ-041 jal (000011) -> JAL cycle shows reg_dst=10, mem_to_reg=10, pc_src=10; with CNT_W=2, 4 retired instructions -> inst_count wraps to 0.
